// File: rtl/mul_div_unit.sv
// Multi-cycle radix-2 multiply/divide unit with valid/ready handshake and flush.
// Optional MDU_FAST_MUL_EN: multiplies complete combinationally at accept.
//
// state | meaning
// IDLE  | waiting for operands; in_ready high
// ITER  | one shift-add or restoring-divide step per cycle
// FIX   | apply result signs and select the result half
// DONE  | result held; out_valid high until out_ready
module mul_div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   input  logic             cancel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result
);

   typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_e;

   localparam logic [2:0] OP_MULH = 3'b001;
   localparam logic [2:0] OP_DIV  = 3'b100;
   localparam logic [2:0] OP_MOD  = 3'b101;

   state_e               state_q, state_d;
   logic [2:0]           op_q, op_d;
   logic [WIDTH-1:0]     a_q, a_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 sign1_q, sign1_d, sign2_q, sign2_d;
   logic [WIDTH-1:0]     result_q, result_d;

   logic                 is_signed, neg1, neg2, div_zero;
   logic [WIDTH-1:0]     mag1, mag2, hi, lo, quot, rem, fix_res;
   logic [WIDTH:0]       mul_sum, rem_t, div_diff;
   logic [2*WIDTH-1:0]   mul_next, div_next, prod;

   assign is_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_MOD);
   assign neg1      = is_signed & src1[WIDTH-1];
   assign neg2      = is_signed & src2[WIDTH-1];
   assign mag1      = neg1 ? -src1 : src1;
   assign mag2      = neg2 ? -src2 : src2;
   assign div_zero  = op[2] && (src2 == '0);

   // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
   assign hi       = acc_q[2*WIDTH-1:WIDTH];
   assign lo       = acc_q[WIDTH-1:0];
   assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, a_q} : '0);
   assign mul_next = {mul_sum, lo[WIDTH-1:1]};
   assign rem_t    = {hi, lo[WIDTH-1]};
   assign div_diff = rem_t - {1'b0, a_q};
   assign div_next = div_diff[WIDTH] ? {rem_t[WIDTH-1:0], lo[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0], lo[WIDTH-2:0], 1'b1};

   assign prod = (sign1_q ^ sign2_q) ? -acc_q : acc_q;
   assign quot = (sign1_q ^ sign2_q) ? -lo : lo;
   assign rem  = sign1_q ? -hi : hi;

   always_comb begin
      fix_res = prod[WIDTH-1:0];
      if (op_q[2])
         fix_res = op_q[0] ? rem : quot;
      else if (op_q[1:0] == 2'b01 || op_q[1:0] == 2'b10)
         fix_res = prod[2*WIDTH-1:WIDTH];
   end

`ifdef MDU_FAST_MUL_EN
   logic signed [2*WIDTH-1:0] s_prod;
   logic        [2*WIDTH-1:0] u_prod;
   logic        [WIDTH-1:0]   fast_res;
   assign s_prod = $signed({{WIDTH{src1[WIDTH-1]}}, src1}) * $signed({{WIDTH{src2[WIDTH-1]}}, src2});
   assign u_prod = {{WIDTH{1'b0}}, src1} * {{WIDTH{1'b0}}, src2};
   always_comb begin
      fast_res = u_prod[WIDTH-1:0];
      if (op[1:0] == 2'b01)
         fast_res = s_prod[2*WIDTH-1:WIDTH];
      else if (op[1:0] == 2'b10)
         fast_res = u_prod[2*WIDTH-1:WIDTH];
   end
`endif

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      sign1_d  = sign1_q;
      sign2_d  = sign2_q;
      result_d = result_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               op_d    = op;
               sign1_d = neg1;
               sign2_d = neg2;
               if (div_zero) begin
                  result_d = op[0] ? src1 : '1;
                  state_d  = S_DONE;
               end
`ifdef MDU_FAST_MUL_EN
               else if (!op[2]) begin
                  result_d = fast_res;
                  state_d  = S_DONE;
               end
`endif
               else begin
                  a_d     = op[2] ? mag2 : mag1;
                  acc_d   = {{WIDTH{1'b0}}, (op[2] ? mag1 : mag2)};
                  cnt_d   = CNT_W'(WIDTH - 1);
                  state_d = S_ITER;
               end
            end
         end
         S_ITER: begin
            acc_d = op_q[2] ? div_next : mul_next;
            if (cnt_q == '0)
               state_d = S_FIX;
            else
               cnt_d = cnt_q - CNT_W'(1);
         end
         S_FIX: begin
            result_d = fix_res;
            state_d  = S_DONE;
         end
         S_DONE: begin
            if (out_ready)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // flush beats accept and out_ready; the visible result is left untouched
      if (cancel) begin
         state_d  = S_IDLE;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         a_q      <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         sign1_q  <= 1'b0;
         sign2_q  <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         sign1_q  <= sign1_d;
         sign2_q  <= sign2_d;
         result_q <= result_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign result    = result_q;

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Parametrised multi-cycle integer multiply/divide unit for the LoongArch EXE stage. It sits beside the single-cycle ALU and executes MUL.W, MULH.W, MULH.WU, DIV.W, MOD.W, DIV.WU and MOD.WU. Operands are accepted through a valid/ready handshake, computed iteratively by a shared radix-2 datapath, and the result is held until the consumer takes it. A synchronous cancel discards in-flight work on pipeline flush.

## Interface
Parameters:
- WIDTH, 32, operand and result width in bits. Must be even and ≥ 8.
- CNT_W, $clog2(WIDTH), iteration counter width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- resetn  input  1  reset, asynchronous and active-low.
- in_valid  input  1  operands and op are valid.
- in_ready  output  1  unit can accept; equals (state == IDLE).
- op  input  3  operation select:
  - 000 MUL, low half of the product.
  - 001 MULH, signed high half.
  - 010 MULHU, unsigned high half.
  - 011 treated as MUL.
  - 100 DIV, signed.
  - 101 MOD, signed.
  - 110 DIVU.
  - 111 MODU.
- src1  input  WIDTH  dividend or multiplicand.
- src2  input  WIDTH  divisor or multiplier.
- cancel  input  1  synchronous flush of any in-flight or completed operation.
- out_valid  output  1  result is valid; high only in the DONE state.
- out_ready  input  1  consumer takes the result.
- result  output  WIDTH  registered result.

## Operation
- States: IDLE, ITER, FIX, DONE.
- IDLE → ITER on accept (in_valid & in_ready & ~cancel).
  - Latch op.
  - Latch |src1| and |src2|. Magnitudes are taken only for signed ops (MULH, DIV, MOD); unsigned ops use the raw values.
  - Latch the result-sign flags.
  - Set the counter to WIDTH-1.
- ITER, multiply: one shift-add step per cycle into a 2·WIDTH accumulator.
- ITER, divide: one restoring step per cycle. This produces WIDTH-bit magnitude quotient and remainder registers.
- ITER → FIX when the counter reaches 0. Exactly WIDTH iteration edges occur.
- FIX: apply signs and select the result into the result register; then go to DONE.
  - Product sign = sign1 ^ sign2.
  - Quotient sign = sign1 ^ sign2.
  - Remainder sign = sign1.
  - MUL selects low half; MULH and MULHU select high half; DIV and DIVU select quotient; MOD and MODU select remainder.
- DONE: out_valid = 1. result and out_valid are held stable until out_ready. DONE & out_ready → IDLE.
- Divide by zero is detected at accept (src2 == 0 for any divide op). Go IDLE → DONE directly.
  - Quotient ops return all ones.
  - Remainder ops return src1 unchanged.
- Signed overflow (most-negative ÷ −1): quotient = most-negative value, remainder = 0. This is produced naturally by the magnitude path; no special case is needed.
- cancel at any edge forces state to IDLE. It wins over accept and over out_ready in the same cycle. result keeps its last value; out_valid drops.

## Timing
- Reset values: state IDLE, out_valid 0, result 0, counter 0, sign flags 0. in_ready = 1 while in reset and after reset.
- Iterative latency: accept on edge e, ITER edges e+1..e+WIDTH, FIX edge e+WIDTH+1. out_valid is high in the cycle after edge e+WIDTH+1.
  - For WIDTH = 32, out_valid is high from the 34th cycle counting the accept cycle as cycle 1.
- Divide-by-zero latency: out_valid is high in the cycle after the accept edge.
- Throughput: one operation in flight. in_ready stays low from the accept edge until the edge where DONE & out_ready (or cancel) returns to IDLE. A new accept is possible at the following edge.
- An asynchronous resetn assertion mid-operation immediately returns all registers to their reset values.

## Configuration
- MDU_FAST_MUL_EN defined:
  - Multiply ops (op[2] = 0) compute the full 2·WIDTH signed/unsigned product combinationally at accept.
  - They write result directly and go IDLE → DONE.
  - out_valid is high in the cycle after the accept edge.
  - Divides are unchanged.
- MDU_FAST_MUL_EN undefined: multiplies use the iterative ITER/FIX path with the latency above.

## Test plan
- MUL 0x0000_0007 × 0xFFFF_FFFD (−3) → result 0xFFFF_FFEB. out_valid at the iterative latency, or one cycle after accept with MDU_FAST_MUL_EN.
- MULH 0x8000_0000 × 0x8000_0000 → 0x4000_0000. MULHU 0xFFFF_FFFF × 0xFFFF_FFFF → 0xFFFF_FFFE.
- DIV −7 (0xFFFF_FFF9) ÷ 2 → 0xFFFF_FFFD; MOD of the same operands → 0xFFFF_FFFF. DIV 0x8000_0000 ÷ 0xFFFF_FFFF → 0x8000_0000 with MOD = 0.
- DIVU 5 ÷ 0 → 0xFFFF_FFFF one cycle after accept. MODU 5 ÷ 0 → 0x0000_0005.
- Backpressure: hold out_ready = 0 for 10 cycles after out_valid rises → result and out_valid stay stable and in_ready stays 0. Raise out_ready → in_ready returns to 1 the next cycle.
- Cancel: assert cancel on the 5th ITER cycle → out_valid never rises and in_ready = 1 next cycle. A following DIVU 100 ÷ 7 returns 14. Also assert resetn = 0 mid-DIV → out_valid = 0 and result = 0 immediately.
